tri_edge_rasterizer: RTL

Parametrised wireframe rasterizer. It accepts one screen-space triangle per handshake and walks its three edges with an integer Bresenham stepper. For each covered pixel it emits one framebuffer write (address plus pixel data) under ready/valid backpressure. It sits between the triangle setup stage and the wireframe/colour framebuffer, and adds configurable screen size, configurable pixel depth, backpressure and optional clipping.

---
 rtl/tri_edge_rasterizer_pkg.sv | 48 ++++
 rtl/tri_edge_rasterizer_if.sv | 30 +++
 rtl/tri_edge_rasterizer_line_stepper.sv | 90 +++++++++
 rtl/tri_edge_rasterizer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/tri_edge_rasterizer_pkg.sv
// Shared types for the wireframe rasterizer: vertex/triangle/colour structs,
// coordinate width and the edge-walk state enum.
package defines_package;

    localparam int COORD_W = 12;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } Vertex3D;

    typedef struct packed {
        Vertex3D p;
        Vertex3D q;
        Vertex3D r;
    } Triangle3D;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } Color;

    // Screen-space point; depth is dropped as soon as a triangle is accepted.
    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP0,
        EDGE0,
        SETUP1,
        EDGE1,
        SETUP2,
        EDGE2,
        FIN
    } rast_state_t;

    function automatic point_t to_point(input Vertex3D v);
        return '{x: v.x, y: v.y};
    endfunction

endpackage

// File: rtl/tri_edge_rasterizer_if.sv
// Triangle-in / framebuffer-write-out bundle of the rasterizer; master is the
// rasterizer side, slave is the setup stage plus framebuffer side.
interface tri_edge_rasterizer_if #(
    parameter int PIX_W  = 1,
    parameter int ADDR_W = 17
);
    import defines_package::*;

    Triangle3D          itriangle;
    Color               icolor;
    logic               tri_ready;
    logic               tri_read;
    logic               fb_ready;
    logic               write_en;
    logic [PIX_W-1:0]   wr_data;
    logic [ADDR_W-1:0]  addr;
    logic               done;
    logic               busy;

    modport master (
        input  itriangle, icolor, tri_ready, fb_ready,
        output tri_read, write_en, wr_data, addr, done, busy
    );

    modport slave (
        output itriangle, icolor, tri_ready, fb_ready,
        input  tri_read, write_en, wr_data, addr, done, busy
    );

endinterface

// File: rtl/tri_edge_rasterizer_line_stepper.sv
// Integer Bresenham stepper for one edge; reloaded by the top for each edge.
// at_end flags that the next step lands on the (exclusive) end vertex.
module line_stepper
    import defines_package::*;
(
    input  logic   clk,
    input  logic   n_rst,
    input  logic   load,
    input  logic   advance,
    input  point_t from_pt,
    input  point_t to_pt,
    output coord_t cur_x,
    output coord_t cur_y,
    output logic   at_end
);

    localparam int DW = COORD_W + 1;
    localparam int EW = COORD_W + 2;
    localparam coord_t ONE = coord_t'(1);

    coord_t                x_q, y_q;
    point_t                end_q;
    logic signed [DW-1:0]  dx_q, dy_q;
    logic signed [EW-1:0]  err_q;
    logic                  sx_neg_q, sy_neg_q;

    logic signed [DW-1:0]  ddx, ddy, dx_ld, dy_ld;
    logic signed [EW:0]    e2;
    logic                  step_x, step_y;
    coord_t                x_nxt, y_nxt;
    logic signed [EW-1:0]  err_nxt;

    always_comb begin
        ddx   = DW'($signed(to_pt.x)) - DW'($signed(from_pt.x));
        ddy   = DW'($signed(to_pt.y)) - DW'($signed(from_pt.y));
        dx_ld = ddx[DW-1] ? -ddx : ddx;
        // dy is held as a negative magnitude so both step tests share err.
        dy_ld = ddy[DW-1] ? ddy : -ddy;
    end

    always_comb begin
        e2      = {err_q, 1'b0};
        step_x  = e2 >= (EW+1)'(dy_q);
        step_y  = e2 <= (EW+1)'(dx_q);
        x_nxt   = x_q;
        y_nxt   = y_q;
        err_nxt = err_q;
        if (step_x) begin
            x_nxt   = sx_neg_q ? x_q - ONE : x_q + ONE;
            err_nxt = err_nxt + EW'(dy_q);
        end
        if (step_y) begin
            y_nxt   = sy_neg_q ? y_q - ONE : y_q + ONE;
            err_nxt = err_nxt + EW'(dx_q);
        end
        at_end = (x_nxt == end_q.x) && (y_nxt == end_q.y);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q      <= '0;
            y_q      <= '0;
            end_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else if (load) begin
            x_q      <= from_pt.x;
            y_q      <= from_pt.y;
            end_q    <= to_pt;
            dx_q     <= dx_ld;
            dy_q     <= dy_ld;
            err_q    <= EW'(dx_ld) + EW'(dy_ld);
            sx_neg_q <= ddx[DW-1];
            sy_neg_q <= ddy[DW-1];
        end else if (advance) begin
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            err_q <= err_nxt;
        end
    end

    assign cur_x = x_q;
    assign cur_y = y_q;

endmodule

// File: rtl/tri_edge_rasterizer.sv
// Wireframe triangle rasterizer: walks p->q->r->p emitting one framebuffer write
// per pixel under fb_ready backpressure. Define RAST_CLIP_EN to suppress off-screen writes.
module tri_edge_rasterizer
    import defines_package::*;
#(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int PIX_W    = 1,
    parameter int ADDR_W   = $clog2(SCREEN_W * SCREEN_H)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    tri_edge_rasterizer_if.master bus
);

    rast_state_t state_q, state_d;
    point_t      p_q, q_q, r_q;
    logic        pt_written_q;

    point_t      seg_from, seg_to;
    logic        accept, load, advance, step, write_en, done;
    logic        seg_zero, degen, on_screen, at_end;
    coord_t      cur_x, cur_y;

    assign accept = (state_q == IDLE) && bus.tri_ready;

    always_comb begin
        seg_from = p_q;
        seg_to   = q_q;
        case (state_q)
            SETUP1:  begin seg_from = q_q; seg_to = r_q; end
            SETUP2:  begin seg_from = r_q; seg_to = p_q; end
            default: ;
        endcase
    end

    assign seg_zero = (seg_from == seg_to);
    assign degen    = (p_q == q_q) && (q_q == r_q);

`ifdef RAST_CLIP_EN
    localparam coord_t X_LIM = coord_t'(SCREEN_W);
    localparam coord_t Y_LIM = coord_t'(SCREEN_H);
    assign on_screen = !cur_x[COORD_W-1] && (cur_x < X_LIM) &&
                       !cur_y[COORD_W-1] && (cur_y < Y_LIM);
`else
    assign on_screen = 1'b1;
`endif

    // NOTE: every output of this block gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        write_en = 1'b0;
        advance  = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE:   if (bus.tri_ready) state_d = SETUP0;
            SETUP0: begin load = 1'b1; state_d = seg_zero ? SETUP1 : EDGE0; end
            SETUP1: begin load = 1'b1; state_d = seg_zero ? SETUP2 : EDGE1; end
            SETUP2: begin load = 1'b1; state_d = seg_zero ? FIN    : EDGE2; end
            EDGE0, EDGE1, EDGE2: begin
                // Clipped pixels still take one cycle but never wait on the framebuffer.
                write_en = on_screen;
                advance  = on_screen ? bus.fb_ready : 1'b1;
                if (advance && at_end) begin
                    case (state_q)
                        EDGE0:   state_d = SETUP1;
                        EDGE1:   state_d = SETUP2;
                        default: state_d = FIN;
                    endcase
                end
            end
            FIN: begin
                if (degen && !pt_written_q) begin
                    write_en = on_screen;
                    advance  = on_screen ? bus.fb_ready : 1'b1;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The single-point write in FIN must not move the stepper off p.
    assign step = advance && (state_q != FIN);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            p_q          <= '0;
            q_q          <= '0;
            r_q          <= '0;
            pt_written_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pt_written_q <= (state_q == FIN) && (pt_written_q || advance);
            if (accept) begin
                p_q <= to_point(bus.itriangle.p);
                q_q <= to_point(bus.itriangle.q);
                r_q <= to_point(bus.itriangle.r);
            end
        end
    end

    line_stepper u_stepper (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (load),
        .advance (step),
        .from_pt (seg_from),
        .to_pt   (seg_to),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .at_end  (at_end)
    );

    if (PIX_W == 24) begin : g_rgb
        Color col_q;
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst)      col_q <= '0;
            else if (accept) col_q <= bus.icolor;
        end
        assign bus.wr_data = {col_q.r, col_q.g, col_q.b};
    end else begin : g_mono
        // Ink is 0 on a background of 1s.
        assign bus.wr_data = '0;
    end

    assign bus.addr     = ADDR_W'($unsigned(cur_y)) * ADDR_W'(SCREEN_W) + ADDR_W'($unsigned(cur_x));
    assign bus.write_en = write_en;
    assign bus.tri_read = (state_q == SETUP0);
    assign bus.done     = done;
    assign bus.busy     = (state_q != IDLE);

endmodule
